fir_operand_sequencer: RTL and testbench

//  Upstream operand feeder for the FIR ALU stage. Accepts one 16-bit input sample per

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_tag_pipe.sv | 40 ++++
 rtl/fir_operand_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_fir_operand_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR operand sequencer: ALU op codes,
// sequencer states, tag layout and the circular-index helper.
package fir_pkg;

  // ALU operation select codes
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  // Default datapath widths
  localparam int DATA_W   = 16;
  localparam int RESULT_W = 32;

  // Tag layout: {valid, first, last}
  localparam int TAG_W     = 3;
  localparam int TAG_VALID = 2;
  localparam int TAG_FIRST = 1;
  localparam int TAG_LAST  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // (head - k) mod ntaps with an explicit wrap, valid for any ntaps
  // (not only powers of two) as long as head and k are in [0, ntaps).
  function automatic int tap_index(input int head, input int k, input int ntaps);
    if (head >= k) begin
      return head - k;
    end else begin
      return head + ntaps - k;
    end
  endfunction

endpackage

// File: rtl/fir_tag_pipe.sv
// DEPTH-stage shift register carrying {valid, first, last} tags alongside the
// ALU pipeline. Asynchronous active-low clear so a reset mid-pass drops every
// in-flight tag.
module fir_tag_pipe
  import fir_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  // chain[0] is the input, chain[DEPTH] the oldest stage
  logic [TAG_W-1:0] chain [DEPTH+1];

  assign chain[0] = tag_in;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [TAG_W-1:0] stage_reg;

      // One pipeline stage: shift the previous stage in every cycle
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = stage_reg;
    end
  endgenerate

  assign tag_out = chain[DEPTH];

endmodule

// File: rtl/fir_operand_sequencer.sv
// FIR operand sequencer: accepts one sample per handshake into a circular
// delay line, then issues NTAPS (sample, coefficient) MUL pairs back to back,
// followed by an ALU_LAT-cycle drain. prod_* tags emerge ALU_LAT cycles after
// each issue, aligned with the ALU result.
// Optional build macro: COEF_WR_GUARD_EN -- drops coefficient writes while a
// pass is in progress and reports them on coef_err.
module fir_operand_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS   = 64,
  parameter int DATA_W  = fir_pkg::DATA_W,
  parameter int ALU_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [DATA_W-1:0]        coef_wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [1:0]               alu_op_sel,
  output logic                     prod_valid,
  output logic                     prod_first,
  output logic                     prod_last,
`ifdef COEF_WR_GUARD_EN
  output logic                     busy,
  output logic                     coef_err
`else
  output logic                     busy
`endif
);

  localparam int IDX_W = $clog2(NTAPS);
  localparam int CNT_W = $clog2(ALU_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_K     = IDX_W'(NTAPS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ALU_LAT - 1);

  seq_state_t state_reg, state_next;

  logic [IDX_W-1:0] wr_ptr_reg;
  logic [IDX_W-1:0] head_reg;
  logic [IDX_W-1:0] k_reg, k_next;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] drain_reg, drain_next;

  logic accept;
  logic coef_wr_en;

  logic [DATA_W-1:0] line_reg [NTAPS];
  logic [DATA_W-1:0] coef_reg [NTAPS];

  logic [DATA_W-1:0] alu_a_reg, alu_a_next;
  logic [DATA_W-1:0] alu_b_reg, alu_b_next;
  logic [1:0]        op_reg, op_next;
  logic [TAG_W-1:0]  tag_issue_reg, tag_next;
  logic [TAG_W-1:0]  tag_out;
  logic              in_ready_reg;
  logic              busy_reg;

  // Newest sample sits at head; tap k looks k samples back in time.
  assign rd_idx = IDX_W'(tap_index(int'(head_reg), int'(k_reg), NTAPS));

`ifdef COEF_WR_GUARD_EN
  logic coef_err_reg;
  assign coef_wr_en = coef_we && !busy_reg;
`else
  assign coef_wr_en = coef_we;
`endif

  // Next-state, tap counter and next operand/tag values
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    drain_next = drain_reg;
    accept     = 1'b0;
    alu_a_next = '0;
    alu_b_next = '0;
    op_next    = OP_ADD;
    tag_next   = '0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready_reg) begin
          accept     = 1'b1;
          k_next     = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        alu_a_next           = line_reg[rd_idx];
        alu_b_next           = coef_reg[k_reg];
        op_next              = OP_MUL;
        tag_next[TAG_VALID]  = 1'b1;
        tag_next[TAG_FIRST]  = (k_reg == '0);
        tag_next[TAG_LAST]   = (k_reg == LAST_K);
        if (k_reg == LAST_K) begin
          drain_next = '0;
          state_next = DRAIN;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          state_next = IDLE;
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus tap and drain counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      drain_reg <= drain_next;
    end
  end

  // Delay line: store the accepted sample and advance the write pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        line_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      head_reg   <= '0;
    end else if (accept) begin
      line_reg[wr_ptr_reg] <= in_data;
      head_reg             <= wr_ptr_reg;
      wr_ptr_reg           <= (wr_ptr_reg == LAST_K) ? '0 : wr_ptr_reg + 1'b1;
    end
  end

  // Coefficient store; a write on the accept cycle lands before the first read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_reg[i] <= '0;
      end
    end else if (coef_wr_en) begin
      coef_reg[coef_addr] <= coef_wdata;
    end
  end

  // Registered operand, op-select, issue tag and handshake/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      op_reg        <= OP_ADD;
      tag_issue_reg <= '0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      op_reg        <= op_next;
      tag_issue_reg <= tag_next;
      in_ready_reg  <= (state_next == IDLE);
      busy_reg      <= (state_next != IDLE);
    end
  end

`ifdef COEF_WR_GUARD_EN
  // Flag a coefficient write that arrived while a pass was running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef_err_reg <= 1'b0;
    end else begin
      coef_err_reg <= coef_we && busy_reg;
    end
  end

  assign coef_err = coef_err_reg;
`endif

  // The issue tag travels with the operands; the pipe delays it so prod_*
  // line up with the ALU result ALU_LAT cycles after the operands appear.
  fir_tag_pipe #(
    .DEPTH (ALU_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_issue_reg),
    .tag_out (tag_out)
  );

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_op_sel = op_reg;
  assign in_ready   = in_ready_reg;
  assign busy       = busy_reg;
  assign prod_valid = tag_out[TAG_VALID];
  assign prod_first = tag_out[TAG_FIRST];
  assign prod_last  = tag_out[TAG_LAST];

endmodule

// File: tb/tb_fir_operand_sequencer.sv
// Scoreboard bench for fir_operand_sequencer (NTAPS=4, ALU_LAT=3).
// The reference model keeps the sample history as a newest-first list and
// derives each pass's expected operand pairs from it at accept time; a monitor
// checks operands, tags and tag timing whenever the DUT presents them.
module tb_fir_operand_sequencer;

  localparam int NTAPS       = 4;
  localparam int ALU_LAT     = 3;
  localparam int DATA_W      = 16;
  localparam int PASS_CYCLES = NTAPS + ALU_LAT + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              coef_we = 1'b0;
  logic [1:0]        coef_addr = '0;
  logic [DATA_W-1:0] coef_wdata = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op_sel;
  logic              prod_valid;
  logic              prod_first;
  logic              prod_last;
  logic              busy;
`ifdef COEF_WR_GUARD_EN
  logic              coef_err;
`endif

  always #5 clk = ~clk;

  fir_operand_sequencer #(
    .NTAPS   (NTAPS),
    .DATA_W  (DATA_W),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op_sel (alu_op_sel),
    .prod_valid (prod_valid),
    .prod_first (prod_first),
    .prod_last  (prod_last),
`ifdef COEF_WR_GUARD_EN
    .busy       (busy),
    .coef_err   (coef_err)
`else
    .busy       (busy)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    int                k;
  } op_t;

  typedef struct {
    int due;
    bit first;
    bit last;
  } prod_t;

  op_t               op_q[$];
  prod_t             prod_q[$];
  logic [DATA_W-1:0] hist[$];          // newest sample first
  logic [DATA_W-1:0] coef_model [NTAPS];

  int n_checks   = 0;
  int n_errors   = 0;
  int ncyc       = 0;
  int n_acc      = 0;
  int last_acc   = -1;
  int prev_acc   = -1;
  int last_issue = -100;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s (cycle %0d)", name, why, ncyc);
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: record accepts, compare issued operands and product tags
  always @(negedge clk) begin : monitor
    op_t   e;
    prod_t p;
    ncyc++;
    if (rst) begin
      if (in_valid && in_ready) begin
        hist.push_front(in_data);
        if (hist.size() > NTAPS) void'(hist.pop_back());
        for (int k = 0; k < NTAPS; k++) begin
          e.a = (k < hist.size()) ? hist[k] : '0;
          e.b = coef_model[k];
          e.k = k;
          op_q.push_back(e);
        end
        prev_acc = last_acc;
        last_acc = ncyc;
        n_acc++;
        $display("accept #%0d: sample=%0d cycle=%0d", n_acc, in_data, ncyc);
      end

      if (alu_op_sel == 2'b01) begin
        if (op_q.size() == 0) begin
          fail("issue_unexpected", "MUL issue with no pass pending");
        end else begin
          e = op_q.pop_front();
          chk($sformatf("alu_a[k=%0d]", e.k), alu_a, e.a);
          chk($sformatf("alu_b[k=%0d]", e.k), alu_b, e.b);
          chk("in_ready_during_issue", in_ready, 0);
          chk("busy_during_issue", busy, 1);
          if (e.k > 0) chk("issue_contiguous", ncyc, last_issue + 1);
          last_issue = ncyc;
          p.due   = ncyc + ALU_LAT;
          p.first = (e.k == 0);
          p.last  = (e.k == NTAPS - 1);
          prod_q.push_back(p);
        end
      end else if (alu_op_sel != 2'b00) begin
        chk("alu_op_sel_legal", alu_op_sel, 0);
      end

      if (prod_valid) begin
        if (prod_q.size() == 0) begin
          fail("prod_unexpected", "prod_valid with no product pending");
        end else begin
          p = prod_q.pop_front();
          chk("prod_timing", ncyc, p.due);
          chk("prod_first", prod_first, p.first);
          chk("prod_last", prod_last, p.last);
        end
      end else if (prod_q.size() > 0 && prod_q[0].due <= ncyc) begin
        void'(prod_q.pop_front());
        fail("prod_missing", "expected prod_valid did not appear");
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 60; i++) begin
      if (in_ready) return;
      step();
    end
    fail("wait_ready", "in_ready never returned");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (in_ready && op_q.size() == 0 && prod_q.size() == 0) return;
      step();
    end
    fail("wait_drain", "pass did not complete");
  endtask

  task automatic write_coef(input int addr, input logic [DATA_W-1:0] data);
    wait_ready();
    coef_we    = 1'b1;
    coef_addr  = 2'(addr);
    coef_wdata = data;
    coef_model[addr] = data;
    step();
    coef_we = 1'b0;
  endtask

  // Offer one sample; optionally wait for idle first and write a coefficient
  // on the same cycle as the accept.
  task automatic push_sample(input logic [DATA_W-1:0] s, input bit wait_first,
                             input bit wr, input int addr, input logic [DATA_W-1:0] data);
    int start;
    bit ok;
    if (wait_first) wait_ready();
    start    = n_acc;
    in_valid = 1'b1;
    in_data  = s;
    if (wr && in_ready) begin
      coef_we    = 1'b1;
      coef_addr  = 2'(addr);
      coef_wdata = data;
      coef_model[addr] = data;
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      coef_we = 1'b0;
      if (n_acc != start) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) fail("accept_timeout", "sample never accepted");
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int mul_seen;
    for (int i = 0; i < NTAPS; i++) coef_model[i] = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_op_sel", alu_op_sel, 0);
    chk("reset_prod_valid", prod_valid, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    step();

    // coef = {1,2,3,4}, single sample into zero history
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'(i + 1));
    push_sample(16'd10, 1'b1, 1'b0, 0, '0);
    wait_drain();

    // Five passes, wrapping the write pointer
    for (int i = 1; i <= 5; i++) push_sample(16'(10 * i), 1'b1, 1'b0, 0, '0);
    wait_drain();

    // Sample held while busy: accepted on return to idle, one pass each
    push_sample(16'd60, 1'b1, 1'b0, 0, '0);
    push_sample(16'd20, 1'b0, 1'b0, 0, '0);
    chk("back_to_back_spacing", last_acc - prev_acc, PASS_CYCLES);
    wait_drain();

`ifdef COEF_WR_GUARD_EN
    // Coefficient write during a pass is rejected
    push_sample(16'd77, 1'b1, 1'b0, 0, '0);
    for (int i = 0; i < 10 && alu_op_sel != 2'b01; i++) step();
    chk("guard_in_issue", alu_op_sel, 1);
    coef_we    = 1'b1;
    coef_addr  = 2'd2;
    coef_wdata = 16'd9;
    step();
    coef_we = 1'b0;
    chk("coef_err_pulse", coef_err, 1);
    step();
    chk("coef_err_clear", coef_err, 0);
    wait_drain();
    push_sample(16'd5, 1'b1, 1'b0, 0, '0);
    wait_drain();
`endif

    // Randomised traffic: gaps, held samples and coefficient updates
    for (int t = 0; t < 24; t++) begin
      int mode;
      repeat ($urandom_range(0, 3)) step();
      mode = $urandom_range(0, 2);
      case (mode)
        0: push_sample(16'($urandom), 1'b1, 1'b1, $urandom_range(0, NTAPS - 1), 16'($urandom));
        1: push_sample(16'($urandom), 1'b1, 1'b0, 0, '0);
        default: push_sample(16'($urandom), 1'b0, 1'b0, 0, '0);
      endcase
    end
    wait_drain();

    // Reset at the second issue cycle of a pass
    push_sample(16'd1234, 1'b1, 1'b0, 0, '0);
    mul_seen = 0;
    for (int i = 0; i < 10 && mul_seen < 2; i++) begin
      if (alu_op_sel == 2'b01) mul_seen++;
      if (mul_seen < 2) step();
    end
    chk("reset_at_issue2", mul_seen, 2);
    rst = 1'b0;
    hist.delete();
    op_q.delete();
    prod_q.delete();
    for (int i = 0; i < NTAPS; i++) coef_model[i] = '0;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_reset_prod_valid", prod_valid, 0);
      chk("post_reset_op_sel", alu_op_sel, 0);
    end

    // History after reset must be all zero
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'(i + 5));
    push_sample(16'd100, 1'b1, 1'b0, 0, '0);
    push_sample(16'd200, 1'b1, 1'b0, 0, '0);
    push_sample(16'd300, 1'b1, 1'b0, 0, '0);
    wait_drain();

    chk("ops_outstanding", op_q.size(), 0);
    chk("prods_outstanding", prod_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
